inst_loader: RTL and testbench

Boot-time instruction loader that writes programs into the instruction memory read by the fetch stage. It receives a byte stream from the host link (UART receiver) over a valid/ready handshake and packs each 8 bytes into one 64-bit bundle: upper-pipe instruction in [63:32], lower-pipe instruction in [31:0]. It writes each bundle to consecutive instruction-memory addresses and holds the core in reset until the whole program has been written.

---
 rtl/loader_pkg.sv | 9 +
 rtl/byte_packer.sv | 28 ++
 rtl/inst_loader.sv | 113 +++++++++++
 tb/tb_inst_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and framing constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {LEN, DATA, WRITE, DONE, ERR} state_t;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 8;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: 64-bit shift register with a 3-bit byte counter.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [63:0] data,
  output logic [2:0]  count,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en) begin
      data  <= {data[55:0], din};
      count <= count + 3'd1;
    end
  end

  // High on the edge that shifts in the last byte of a bundle.
  assign full = shift_en && (count == 3'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// Boot loader: packs a length-prefixed byte stream into 64-bit instruction-memory writes.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [63:0]       imem_din,
  output logic              imem_we,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              err
);

  state_t            state_q, state_d;
  logic              run_q;
  logic [31:0]       len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   wcnt_inc;
  logic [31:0]       len_next;
  logic              len_load;
  logic              accept;
  logic              pk_clear, pk_shift, pk_full;
  logic [63:0]       pk_data;
  logic [2:0]        pk_count;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .din      (rx_data),
    .data     (pk_data),
    .count    (pk_count),
    .full     (pk_full)
  );

  // run_q holds rx_ready low for the first cycle after reset releases.
  assign rx_ready = run_q && (state_q == LEN || state_q == DATA);
  assign busy     = run_q && (state_q == LEN || state_q == DATA || state_q == WRITE);
  assign imem_we  = (state_q == WRITE);
  assign cpu_rstn = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign imem_addr = wcnt_q[ADDR_W-1:0];
  assign imem_din  = pk_data;

  assign accept   = rx_valid && rx_ready;
  assign wcnt_inc = wcnt_q + 1'b1;
  assign len_next = {pk_data[23:0], rx_data};

  always_comb begin
    state_d  = state_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    len_load = 1'b0;
    case (state_q)
      LEN: begin
        if (accept) begin
          if (pk_count == 3'(LEN_BYTES - 1)) begin
            len_load = 1'b1;
            pk_clear = 1'b1;
            if (len_next == 32'd0)
              state_d = DONE;
            else if ({1'b0, len_next} > (33'd1 << ADDR_W))
              state_d = ERR;
            else
              state_d = DATA;
          end else begin
            pk_shift = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
          if (pk_full)
            state_d = WRITE;
        end
      end
      WRITE: begin
        // Counter is one bit wider than the address so L = 2**ADDR_W ends cleanly.
        state_d = (32'(wcnt_inc) == len_q) ? DONE : DATA;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LEN;
      run_q   <= 1'b0;
      len_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (len_load) begin
        len_q  <= len_next;
        wcnt_q <= '0;
      end else if (state_q == WRITE) begin
        wcnt_q <= wcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table of load scenarios plus reset corner sequences.
module tb_inst_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a_rx_data, b_rx_data;
  logic        a_rx_valid, b_rx_valid;
  logic        a_rx_ready, b_rx_ready;
  logic [14:0] a_imem_addr;
  logic [1:0]  b_imem_addr;
  logic [63:0] a_imem_din, b_imem_din;
  logic        a_imem_we, b_imem_we;
  logic        a_cpu_rstn, b_cpu_rstn;
  logic        a_busy, b_busy;
  logic        a_err, b_err;

  inst_loader #(.ADDR_W(15)) dut_a (
    .clk(clk), .rst(rst), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .imem_addr(a_imem_addr), .imem_din(a_imem_din), .imem_we(a_imem_we),
    .cpu_rstn(a_cpu_rstn), .busy(a_busy), .err(a_err)
  );

  inst_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .imem_addr(b_imem_addr), .imem_din(b_imem_din), .imem_we(b_imem_we),
    .cpu_rstn(b_cpu_rstn), .busy(b_busy), .err(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Write log and protocol-violation counters, sampled on the falling edge.
  logic [63:0] wq_din[$];
  int          wq_addr[$];
  int          wq_sel[$];
  int          we_bad = 0;
  int          busy_bad = 0;
  logic        a_we_prev = 1'b0, b_we_prev = 1'b0;

  always @(negedge clk) begin
    if (a_imem_we === 1'b1) begin
      wq_din.push_back(a_imem_din); wq_addr.push_back(int'(a_imem_addr)); wq_sel.push_back(0);
    end
    if (b_imem_we === 1'b1) begin
      wq_din.push_back(b_imem_din); wq_addr.push_back(int'(b_imem_addr)); wq_sel.push_back(1);
    end
    if (a_imem_we === 1'b1 && a_we_prev === 1'b1) we_bad++;
    if (b_imem_we === 1'b1 && b_we_prev === 1'b1) we_bad++;
    a_we_prev = a_imem_we;
    b_we_prev = b_imem_we;
    if (((a_rx_ready === 1'b1 || a_imem_we === 1'b1) && a_busy !== 1'b1) ||
        ((a_cpu_rstn === 1'b1 || a_err === 1'b1) && a_busy !== 1'b0)) busy_bad++;
    if (((b_rx_ready === 1'b1 || b_imem_we === 1'b1) && b_busy !== 1'b1) ||
        ((b_cpu_rstn === 1'b1 || b_err === 1'b1) && b_busy !== 1'b0)) busy_bad++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin a_rx_valid = v; a_rx_data = d; end
    else          begin b_rx_valid = v; b_rx_data = d; end
  endtask

  function automatic logic g_ready(input int sel);
    return (sel == 0) ? a_rx_ready : b_rx_ready;
  endfunction
  function automatic logic g_we(input int sel);
    return (sel == 0) ? a_imem_we : b_imem_we;
  endfunction
  function automatic logic g_rstn(input int sel);
    return (sel == 0) ? a_cpu_rstn : b_cpu_rstn;
  endfunction
  function automatic logic g_err(input int sel);
    return (sel == 0) ? a_err : b_err;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel == 0) ? a_busy : b_busy;
  endfunction
  function automatic logic [63:0] g_addr(input int sel);
    return (sel == 0) ? 64'(a_imem_addr) : 64'(b_imem_addr);
  endfunction
  function automatic logic [63:0] g_din(input int sel);
    return (sel == 0) ? a_imem_din : b_imem_din;
  endfunction

  // Presents one byte and returns #1 after the edge that accepted it; valid stays high.
  task automatic send_byte(input int sel, input logic [7:0] b, input bit gaps);
    logic r;
    int   n;
    r = 1'b0;
    if (gaps) begin
      drive(sel, 1'b0, 8'h00);
      n = $urandom_range(0, 3);
      repeat (n) begin @(posedge clk); #1; end
    end
    drive(sel, 1'b1, b);
    for (int k = 0; k < 40; k++) begin
      r = g_ready(sel);
      @(posedge clk); #1;
      if (r) break;
    end
    if (!r) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: rx_ready got 0 expected 1 (byte %h)", b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int              sel;
    logic [31:0]     len;
    int              nb;
    logic [3:0][63:0] bund;
    bit              gaps;
    bit              exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic set_vec(input int i, input int sel, input logic [31:0] len, input int nb,
                         input bit gaps, input bit exp_err,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3);
    vecs[i].sel = sel; vecs[i].len = len; vecs[i].nb = nb;
    vecs[i].gaps = gaps; vecs[i].exp_err = exp_err;
    vecs[i].bund[0] = b0; vecs[i].bund[1] = b1; vecs[i].bund[2] = b2; vecs[i].bund[3] = b3;
  endtask

  initial begin
    vec_t        v;
    int          base, bb, wb, nw, sel;
    logic [63:0] bw;

    set_vec(0, 0, 32'd1, 1, 1'b0, 1'b0, 64'h1122334455667788, '0, '0, '0);
    set_vec(1, 0, 32'd0, 0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_vec(2, 0, 32'd3, 3, 1'b1, 1'b0, 64'h0000000100000002, 64'h0000000300000004,
            64'h0000000500000006, '0);
    set_vec(3, 1, 32'd5, 0, 1'b0, 1'b1, '0, '0, '0, '0);
    set_vec(4, 1, 32'd4, 4, 1'b1, 1'b0, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7,
            64'hC0C1C2C3C4C5C6C7, 64'hFFEEDDCCBBAA9988);

    // Reset values; a byte offered during reset must be ignored.
    rst = 1'b1;
    drive(0, 1'b1, 8'h55);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 64'(a_rx_ready), 64'd0);
    check("rst_imem_we",  64'(a_imem_we),  64'd0);
    check("rst_imem_addr", 64'(a_imem_addr), 64'd0);
    check("rst_imem_din", a_imem_din, 64'd0);
    check("rst_cpu_rstn", 64'(a_cpu_rstn), 64'd0);
    check("rst_busy",     64'(a_busy),     64'd0);
    check("rst_err",      64'(a_err),      64'd0);
    rst = 1'b0;
    check("post_rst_ready_low", 64'(a_rx_ready), 64'd0);
    @(posedge clk); #1;
    check("post_rst_ready_high", 64'(a_rx_ready), 64'd1);
    check("post_rst_busy", 64'(a_busy), 64'd1);
    drive(0, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      sel = v.sel;
      do_reset();
      base = wq_din.size(); bb = busy_bad; wb = we_bad;
      for (int j = 3; j >= 0; j--) send_byte(sel, v.len[8*j +: 8], v.gaps);
      if (v.nb == 0) begin
        drive(sel, 1'b0, 8'h00);
        check($sformatf("v%0d_err", i),   64'(g_err(sel)),   64'(v.exp_err));
        check($sformatf("v%0d_rstn", i),  64'(g_rstn(sel)),  64'(!v.exp_err));
        check($sformatf("v%0d_ready", i), 64'(g_ready(sel)), 64'd0);
        // Extra bytes after the terminal state must never be taken.
        drive(sel, 1'b1, 8'hAA);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("v%0d_extra_ready", i), 64'(g_ready(sel)), 64'd0);
        end
        drive(sel, 1'b0, 8'h00);
        @(posedge clk); #1;
        check($sformatf("v%0d_rstn_hold", i), 64'(g_rstn(sel)), 64'(!v.exp_err));
      end else begin
        for (int j = 0; j < v.nb; j++) begin
          bw = v.bund[j];
          for (int k = 7; k >= 0; k--) send_byte(sel, bw[8*k +: 8], v.gaps);
          if (j == v.nb - 1) drive(sel, 1'b0, 8'h00);
          check($sformatf("v%0d_we_b%0d", i, j),   64'(g_we(sel)), 64'd1);
          check($sformatf("v%0d_addr_b%0d", i, j), g_addr(sel),    64'(j));
          check($sformatf("v%0d_din_b%0d", i, j),  g_din(sel),     bw);
          if (j < v.nb - 1)
            check($sformatf("v%0d_rstn_mid", i), 64'(g_rstn(sel)), 64'd0);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d_done_rstn", i),  64'(g_rstn(sel)),  64'd1);
        check($sformatf("v%0d_done_we", i),    64'(g_we(sel)),    64'd0);
        check($sformatf("v%0d_done_ready", i), 64'(g_ready(sel)), 64'd0);
        check($sformatf("v%0d_done_busy", i),  64'(g_busy(sel)),  64'd0);
        check($sformatf("v%0d_done_err", i),   64'(g_err(sel)),   64'd0);
      end
      repeat (2) @(posedge clk); #1;
      nw = wq_din.size() - base;
      check($sformatf("v%0d_nwrites", i), 64'(nw), 64'(v.exp_err ? 0 : v.nb));
      for (int j = 0; j < nw && j < v.nb; j++) begin
        check($sformatf("v%0d_log_addr%0d", i, j), 64'(wq_addr[base+j]), 64'(j));
        check($sformatf("v%0d_log_din%0d", i, j),  wq_din[base+j], v.bund[j]);
        check($sformatf("v%0d_log_sel%0d", i, j),  64'(wq_sel[base+j]), 64'(sel));
      end
      check($sformatf("v%0d_we_width", i), 64'(we_bad - wb), 64'd0);
      check($sformatf("v%0d_busy_rule", i), 64'(busy_bad - bb), 64'd0);
    end

    // Reset mid-load: L = 2, full bundle 0 then 5 bytes of bundle 1.
    do_reset();
    base = wq_din.size();
    for (int j = 3; j >= 0; j--) send_byte(0, 8'(j == 0 ? 2 : 0), 1'b0);
    for (int k = 0; k < 8; k++) send_byte(0, 8'hA0 + 8'(k), 1'b0);
    for (int k = 0; k < 5; k++) send_byte(0, 8'hB0 + 8'(k), 1'b0);
    drive(0, 1'b0, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 64'(a_rx_ready), 64'd0);
    check("midrst_busy",  64'(a_busy),     64'd0);
    check("midrst_addr",  64'(a_imem_addr), 64'd0);
    check("midrst_din",   a_imem_din,      64'd0);
    check("midrst_rstn",  64'(a_cpu_rstn), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int j = 3; j >= 0; j--) send_byte(0, 8'(j == 0 ? 1 : 0), 1'b0);
    bw = 64'hDEADBEEF01234567;
    for (int k = 7; k >= 0; k--) send_byte(0, bw[8*k +: 8], 1'b0);
    drive(0, 1'b0, 8'h00);
    @(posedge clk); #1;
    check("midrst_reload_rstn", 64'(a_cpu_rstn), 64'd1);
    check("midrst_nwrites", 64'(wq_din.size() - base), 64'd2);
    if (wq_din.size() - base >= 2) begin
      check("midrst_w0_din",  wq_din[base],    64'hA0A1A2A3A4A5A6A7);
      check("midrst_w1_addr", 64'(wq_addr[base+1]), 64'd0);
      check("midrst_w1_din",  wq_din[base+1],  bw);
    end

    // Reset while DONE drops cpu_rstn on the next cycle.
    rst = 1'b1;
    @(posedge clk); #1;
    check("done_rst_rstn", 64'(a_cpu_rstn), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
